ifetch_queue: RTL
=================

# ifetch_queue

Instruction-fetch front end for the MIPS core. It owns the program counter, drives the word address into the instruction ROM and captures the returned instruction together with its PC. Captured pairs go into a small FIFO that decode drains through a valid/ready handshake. Branch, jump and `jr` resolution later in the pipe redirect it through a single-cycle redirect port that flushes all queued entries.

## Interface

Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `a`  out  32  ROM address, equal to the PC register; combinational from state only.
- `inst`  in  32  ROM read data for `a`, valid in the same cycle.
- `redirect`  in  1  one-cycle request to flush the queue and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC, sampled when `redirect`=1.
- `out_valid`  out  1  queue head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_inst`  out  32  instruction at the queue head.
- `out_pc`  out  32  PC of the queue head.
- `misalign`  out  1  sticky flag for a misaligned redirect target (see Configuration).

## Operation

- State:
  - `pc` (32 bits).
  - Queue storage `{pc, inst}` × `DEPTH`.
  - Read and write pointers, each log2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - `count`, log2(`DEPTH`)+1 bits.
  - `misalign` flag.
- `pop` = `out_valid & out_ready`.
- `push` = `!redirect & (count < DEPTH | pop)`. A full queue with a simultaneous pop still accepts a push.
- On `push`:
  - Write `{pc, inst}` at the write pointer.
  - `pc <= pc + 4`, wrapping modulo 2^32, so 0xFFFF_FFFC → 0x0000_0000.
- Without `push` and without `redirect`, `pc` holds.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together.
- On `redirect`, which has priority over everything else:
  - Read pointer, write pointer and `count` clear to 0.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No push that cycle.
  - A pop in the same cycle is discarded; the flush wins.
- `out_valid` = (`count` != 0).
- `out_inst` and `out_pc` are read combinationally at the read pointer. When `out_valid`=0 they are don't-care, but must not be X after reset; drive storage reset to 0.
- `out_inst` and `out_pc` must stay stable while `out_valid=1 & out_ready=0`.

## Timing

- Reset values:
  - `pc` = `RESET_PC`, so `a` = `RESET_PC`.
  - `count` = 0 and `out_valid` = 0.
  - `out_inst` = 0 and `out_pc` = 0.
  - `misalign` = 0.
- First fetch occurs in the first cycle after `rst` deasserts. `out_valid` rises on the following cycle (1-cycle fetch-to-decode latency).
- Steady state with `out_ready` held at 1: one instruction per cycle, and the queue holds 1 entry.
- Redirect asserted in cycle N:
  - `a` = target in N+1.
  - The target instruction is visible on `out_*` in N+2.
  - `out_valid`=0 in N+1.
- Full queue with `out_ready`=0: `pc` and `a` freeze. Fetch resumes in the same cycle `out_ready` rises (pop+push).
- `rst` asserted mid-operation overrides `redirect`, push and pop, and restores all reset values at that edge.

## Configuration

- `IFETCH_ALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign` to 1.
  - `misalign` stays 1 until `rst`.
  - The fetch still proceeds from the aligned address.
- Undefined:
  - `misalign` is tied to 0.
  - Low bits are dropped silently.
  - No check logic is generated.

## Test plan

- Reset release, `out_ready`=1, standard program loaded in the ROM → `out_pc`/`out_inst` sequence 0x00/3c010000, 0x04/34240050, 0x08/20050004, one per cycle, starting 2 cycles after reset release.
- `out_ready`=0 for 10 cycles after reset → `count`=4, `a` frozen at 0x10, head stays 0x00/3c010000. Then raise `out_ready` → 0x00, 0x04, 0x08, 0x0C, 0x10 drain with no gap.
- Redirect to 0x60 while 3 entries are queued → `out_valid`=0 next cycle, then 0x60/00004020 followed by 0x64/8c890000. No stale entry appears.
- `RESET_PC`=32'hFFFF_FFFC → first output pc 0xFFFF_FFFC, next 0x0000_0000 with inst 3c010000.
- `rst` pulsed while the queue is full and `redirect` is asserted in the same cycle → all reset values restored, and the fetch restarts at `RESET_PC`.
- `IFETCH_ALIGN_CHK_EN` defined, redirect to 0x62 → `misalign`=1, next output 0x60/00004020, `misalign` still 1 after 20 cycles. With the macro undefined → `misalign` stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, captures {pc, inst} from the ROM into a
// small FIFO for decode. Optional redirect-alignment check under IFETCH_ALIGN_CHK_EN.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] a,
    input  logic [31:0] inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        misalign
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_pc_d   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [31:0]   mem_inst_d [DEPTH];

    logic pop;
    logic push;

    assign a         = pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign out_inst  = mem_inst_q[rd_ptr_q];

    // A full queue still takes a fetch when decode drains the head in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = !redirect & ((count_q < DEPTH_C) | pop);

    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]   = pc_q;
                mem_inst_d[wr_ptr_q] = inst;
                wr_ptr_d             = wr_ptr_q + AW'(1);
                pc_d                 = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mem_pc_q   <= '{default: '0};
            mem_inst_q <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_pc_q   <= mem_pc_d;
            mem_inst_q <= mem_inst_d;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    logic misalign_q, misalign_d;

    // Sticky until reset so software can inspect it after the fact.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign misalign       = 1'b0;
`endif

endmodule
